mac_scan_ctrl: RTL and testbench

Scan-test controller for the `mac` core; it is the initiator end of the core's `scanin` / `scan_en` / `scanout` chain. It serially loads a test pattern into the scan chain, pulses a capture window, and unloads the captured response. It compares the response against a masked expected vector and keeps a saturating failure count. It sits on the core side of the pad ring, next to `mac`, and is driven by on-chip test logic or a tester through a simple start/done handshake.

---
 rtl/mac_scan_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mac_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_scan_ctrl.sv
// mac_scan_ctrl -- scan-test initiator for the mac core.
//
// Loads a stimulus pattern into the core scan chain MSB first, drops scan_en
// for a capture window, then unloads the captured response while shifting
// zeros in. The response is compared against a masked expected vector, and
// a saturating count of failed tests is kept.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start, abort      test request (sampled in IDLE) / cancel running test
//   pattern           stimulus vector, latched when start is accepted
//   expected, mask    expected response and compare mask (1 = compared)
//   scan_so           serial data returning from the core scanout
//   scan_en, scan_si  scan-enable and serial data driven to the core
//   busy              test in LOAD/CAPTURE/UNLOAD
//   done              one-cycle pulse, response/fail valid
//   fail, response    result of the last completed test (held until next done)
//   fail_cnt          failed tests since reset, saturating at 255
module mac_scan_ctrl #(
    parameter int CHAIN_LEN   = 32,
    parameter int CAPTURE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    input  logic                 scan_so,
    output logic                 scan_en,
    output logic                 scan_si,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [CHAIN_LEN-1:0] response,
    output logic [7:0]           fail_cnt
);

    // One down-counter times every phase; sized for the longer of the chain
    // and the capture window so a long capture window cannot overflow it.
    localparam int PHASE_MAX = (CAPTURE_CYC > CHAIN_LEN) ? CAPTURE_CYC : CHAIN_LEN;
    localparam int CW        = $clog2(PHASE_MAX + 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(CAPTURE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CHAIN_LEN-1:0] pat_sh;   // remaining load bits, next one at MSB
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic [CHAIN_LEN-1:0] resp_sh;  // unload accumulator; response only updates at done

    logic [CHAIN_LEN-1:0] unload_next;
    logic                 unload_fail;

    assign unload_next = {resp_sh[CHAIN_LEN-2:0], scan_so};
    assign unload_fail = |((unload_next ^ exp_q) & mask_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pat_sh   <= '0;
            exp_q    <= '0;
            mask_q   <= '0;
            resp_sh  <= '0;
            scan_en  <= 1'b0;
            scan_si  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            response <= '0;
            fail_cnt <= '0;
        end else begin
            done <= 1'b0;
            // busy is high exactly in LOAD/CAPTURE/UNLOAD, the states abort acts in;
            // abort wins over phase completion and leaves results untouched.
            if (busy && abort) begin
                state   <= S_IDLE;
                cnt     <= '0;
                scan_en <= 1'b0;
                scan_si <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            pat_sh  <= {pattern[CHAIN_LEN-2:0], 1'b0};
                            exp_q   <= expected;
                            mask_q  <= mask;
                            scan_si <= pattern[CHAIN_LEN-1];
                            scan_en <= 1'b1;
                            busy    <= 1'b1;
                            cnt     <= SHIFT_LAST;
                            state   <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (cnt == '0) begin
                            state   <= S_CAPTURE;
                            cnt     <= CAP_LAST;
                            scan_en <= 1'b0;
                            scan_si <= 1'b0;
                        end else begin
                            cnt     <= cnt - CW'(1);
                            scan_si <= pat_sh[CHAIN_LEN-1];
                            pat_sh  <= {pat_sh[CHAIN_LEN-2:0], 1'b0};
                        end
                    end
                    S_CAPTURE: begin
                        if (cnt == '0) begin
                            state   <= S_UNLOAD;
                            cnt     <= SHIFT_LAST;
                            scan_en <= 1'b1;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    S_UNLOAD: begin
                        // scan_so is the last flop before this edge's shift.
                        resp_sh <= unload_next;
                        if (cnt == '0) begin
                            state    <= S_DONE;
                            cnt      <= '0;
                            scan_en  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            response <= unload_next;
                            fail     <= unload_fail;
                            if (unload_fail && fail_cnt != 8'hFF)
                                fail_cnt <= fail_cnt + 8'd1;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                    default: begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        scan_en <= 1'b0;
                        scan_si <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_scan_ctrl.sv
// Bench for mac_scan_ctrl: two instances (8-bit chain / 1 capture cycle and
// 4-bit chain / 3 capture cycles), each wired to a simple core chain model
// whose capture either holds or inverts the chain.
module tb_mac_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start, abort, inv, scan_so, scan_en, scan_si, busy, done, fail;
    logic [7:0] pattern [2];
    logic [7:0] expected[2];
    logic [7:0] mask    [2];
    logic [7:0] response8, fail_cnt8, fail_cnt4;
    logic [3:0] response4;
    logic [7:0] chain8 = '0;
    logic [3:0] chain4 = '0;

    int checks = 0;
    int errors = 0;

    mac_scan_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYC(1)) dut8 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .pattern(pattern[0]), .expected(expected[0]), .mask(mask[0]),
        .scan_so(scan_so[0]), .scan_en(scan_en[0]), .scan_si(scan_si[0]),
        .busy(busy[0]), .done(done[0]), .fail(fail[0]),
        .response(response8), .fail_cnt(fail_cnt8)
    );

    mac_scan_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYC(3)) dut4 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .pattern(pattern[1][3:0]), .expected(expected[1][3:0]), .mask(mask[1][3:0]),
        .scan_so(scan_so[1]), .scan_en(scan_en[1]), .scan_si(scan_si[1]),
        .busy(busy[1]), .done(done[1]), .fail(fail[1]),
        .response(response4), .fail_cnt(fail_cnt4)
    );

    // Core chain models: shift when scan_en=1, otherwise capture (hold or invert).
    assign scan_so[0] = chain8[7];
    assign scan_so[1] = chain4[3];
    always @(posedge clk) begin
        if (scan_en[0])  chain8 <= {chain8[6:0], scan_si[0]};
        else if (inv[0]) chain8 <= ~chain8;
        if (scan_en[1])  chain4 <= {chain4[2:0], scan_si[1]};
        else if (inv[1]) chain4 <= ~chain4;
    end

    function automatic int nlen(input int d); return (d == 0) ? 8 : 4; endfunction
    function automatic int clen(input int d); return (d == 0) ? 1 : 3; endfunction
    function automatic logic [7:0] resp_of(input int d);
        return (d == 0) ? response8 : {4'b0, response4};
    endfunction
    function automatic logic [7:0] cnt_of(input int d);
        return (d == 0) ? fail_cnt8 : fail_cnt4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A test is described by k = cycle number counted from the accept edge.
    logic [1:0] s_start = '0, s_abort = '0, s_inv = '0;
    logic       s_rst = 1'b0;
    logic [7:0] s_pat[2], s_exp[2], s_msk[2];
    always @(posedge clk) begin
        s_start <= start; s_abort <= abort; s_inv <= inv; s_rst <= rst;
        s_pat <= pattern; s_exp <= expected; s_msk <= mask;
    end

    bit         m_idle[2] = '{1'b1, 1'b1};
    int         m_k[2]    = '{0, 0};
    logic [7:0] m_pat[2], m_exp[2], m_msk[2];
    logic [7:0] m_resp[2] = '{8'h0, 8'h0};
    bit         m_inv[2]  = '{1'b0, 1'b0};
    bit         m_fail[2] = '{1'b0, 1'b0};
    int         m_cnt[2]  = '{0, 0};

    task automatic model_step(input int d);
        int n, c, tot;
        logic [7:0] nm;
        n = nlen(d); c = clen(d); tot = 2*n + c;
        nm = 8'((1 << n) - 1);
        if (!rst || !s_rst) begin
            m_idle[d] = 1; m_k[d] = 0; m_resp[d] = '0; m_fail[d] = 0; m_cnt[d] = 0;
        end else if (m_idle[d]) begin
            if (s_start[d]) begin
                m_idle[d] = 0; m_k[d] = 1;
                m_pat[d] = s_pat[d] & nm; m_exp[d] = s_exp[d] & nm; m_msk[d] = s_msk[d] & nm;
                m_inv[d] = s_inv[d];
            end
        end else if (m_k[d] <= tot && s_abort[d]) begin
            m_idle[d] = 1;
        end else if (m_k[d] == tot + 1) begin
            m_idle[d] = 1;
        end else begin
            m_k[d]++;
            if (m_k[d] == tot + 1) begin
                m_resp[d] = (m_inv[d] && (c % 2 == 1)) ? (~m_pat[d] & nm) : m_pat[d];
                m_fail[d] = |((m_resp[d] ^ m_exp[d]) & m_msk[d]);
                if (m_fail[d] && m_cnt[d] < 255) m_cnt[d]++;
            end
        end
    endtask

    task automatic model_compare(input int d);
        int n, c, k, tot;
        bit e_busy, e_done, e_en, e_si;
        n = nlen(d); c = clen(d); k = m_k[d]; tot = 2*n + c;
        e_busy = !m_idle[d] && k >= 1 && k <= tot;
        e_done = !m_idle[d] && k == tot + 1;
        e_en   = e_busy && (k <= n || k >= n + c + 1);
        e_si   = e_busy && k <= n && m_pat[d][n-k];
        chk($sformatf("d%0d busy", d),     busy[d],    e_busy);
        chk($sformatf("d%0d done", d),     done[d],    e_done);
        chk($sformatf("d%0d scan_en", d),  scan_en[d], e_en);
        chk($sformatf("d%0d scan_si", d),  scan_si[d], e_si);
        chk($sformatf("d%0d fail", d),     fail[d],    m_fail[d]);
        chk($sformatf("d%0d response", d), resp_of(d), m_resp[d]);
        chk($sformatf("d%0d fail_cnt", d), cnt_of(d),  m_cnt[d]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                model_step(d);
                model_compare(d);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge with instance d idle; returns at the done cycle.
    task automatic run(input int d, input logic [7:0] p, input logic [7:0] e,
                       input logic [7:0] m, input logic iv,
                       output int lat, output logic [31:0] en_bits, output logic [31:0] si_bits);
        inv[d] = iv; pattern[d] = p; expected[d] = e; mask[d] = m; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        lat = 1; en_bits = '0; si_bits = '0;
        en_bits[0] = scan_en[d]; si_bits[0] = scan_si[d];
        while (!done[d] && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat <= 32) begin
                en_bits[lat-1] = scan_en[d];
                si_bits[lat-1] = scan_si[d];
            end
        end
        if (!done[d]) chk($sformatf("d%0d done timeout", d), {31'b0, done[d]}, 32'd1);
    endtask

    task automatic wait_idle(input int d);
        int w = 0;
        while ((busy[d] || done[d]) && w < 60) begin @(negedge clk); w++; end
        if (busy[d] || done[d]) chk($sformatf("d%0d idle timeout", d), {31'b0, busy[d]}, 32'd0);
    endtask

    initial begin
        int lat, low, w;
        logic [31:0] enb, sib;
        rst = 1'b0; start = '0; abort = '0; inv = '0;
        for (int d = 0; d < 2; d++) begin pattern[d] = '0; expected[d] = '0; mask[d] = '0; end
        repeat (2) @(negedge clk);
        chk("reset outputs d0", {scan_en[0], scan_si[0], busy[0], done[0], fail[0], response8, fail_cnt8}, 32'd0);
        chk("reset outputs d1", {scan_en[1], scan_si[1], busy[1], done[1], fail[1], response4, fail_cnt4}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Loopback, matching expectation.
        run(0, 8'hA5, 8'hA5, 8'hFF, 1'b0, lat, enb, sib);
        chk("loop latency", lat, 18);
        chk("loop response", response8, 8'hA5);
        chk("loop fail", fail[0], 0);
        chk("loop fail_cnt", fail_cnt8, 0);
        @(negedge clk);
        // Mismatch on bit 0, then masked off.
        run(0, 8'hA5, 8'hA4, 8'hFF, 1'b0, lat, enb, sib);
        chk("mismatch fail", fail[0], 1);
        chk("mismatch fail_cnt", fail_cnt8, 1);
        @(negedge clk);
        run(0, 8'hA5, 8'hA4, 8'hFE, 1'b0, lat, enb, sib);
        chk("masked fail", fail[0], 0);
        chk("masked fail_cnt", fail_cnt8, 1);
        @(negedge clk);
        // Inverting capture.
        run(0, 8'h0F, 8'hF0, 8'hFF, 1'b1, lat, enb, sib);
        chk("invert response", response8, 8'hF0);
        chk("invert scan_en wave", enb, 32'h0001FEFF);
        chk("invert scan_si wave", sib, 32'h000000F0);
        chk("invert fail", fail[0], 0);
        @(negedge clk);

        // Abort in LOAD cycle 5.
        inv[0] = 1'b0; pattern[0] = 8'h33; start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;        // cycle 1
        repeat (4) @(negedge clk);              // cycle 5
        abort[0] = 1'b1;
        @(negedge clk); abort[0] = 1'b0;        // cycle 6
        chk("abort busy", busy[0], 0);
        chk("abort scan_en", scan_en[0], 0);
        w = 0;
        repeat (25) begin @(negedge clk); if (done[0]) w++; end
        chk("abort no done", w, 0);
        chk("abort response kept", response8, 8'hF0);
        chk("abort fail_cnt kept", fail_cnt8, 1);

        // CAPTURE_CYC=3 instance, start pulsed mid-run must be ignored.
        inv[1] = 1'b0; pattern[1] = 8'h0A; expected[1] = 8'h0A; mask[1] = 8'h0F; start[1] = 1'b1;
        @(negedge clk); start[1] = 1'b0;
        lat = 1; low = 0;
        while (!done[1] && lat < 100) begin
            if (busy[1] && !scan_en[1]) low++;
            start[1] = (lat == 4);
            @(negedge clk);
            lat++;
        end
        start[1] = 1'b0;
        chk("cap3 latency", lat, 12);
        chk("cap3 scan_en low", low, 3);
        chk("cap3 response", response4, 4'hA);
        repeat (2) begin @(negedge clk); chk("cap3 no retrigger", busy[1], 0); end
        run(1, 8'h03, 8'h0C, 8'h0F, 1'b1, lat, enb, sib);
        chk("cap3 invert response", response4, 4'hC);
        chk("cap3 invert fail", fail[1], 0);
        @(negedge clk);

        // Randomized runs; the per-cycle model comparison does the checking.
        for (int it = 0; it < 60; it++) begin
            int d, tot, ab_at, st_at;
            d = $urandom_range(0, 1);
            tot = 2*nlen(d) + clen(d);
            ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, tot + 1) : -1;
            st_at = $urandom_range(2, tot);
            if (ab_at >= 0 && ab_at <= st_at) st_at = -1;
            inv[d] = 1'($urandom_range(0, 1));
            pattern[d] = 8'($urandom); expected[d] = 8'($urandom);
            mask[d] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            start[d] = 1'b1;
            for (int cyc = 1; cyc <= tot + 3; cyc++) begin
                @(negedge clk);
                start[d] = (cyc == st_at);
                abort[d] = (cyc == ab_at);
            end
            start[d] = 1'b0; abort[d] = 1'b0;
            wait_idle(d);
            @(negedge clk);
        end

        // Asynchronous reset during UNLOAD.
        inv[0] = 1'b0; pattern[0] = 8'hC3; expected[0] = 8'h00; mask[0] = 8'hFF; start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        repeat (11) @(negedge clk);             // cycle 12, inside UNLOAD
        #3 rst = 1'b0;
        #1;
        chk("async reset d0", {scan_en[0], scan_si[0], busy[0], done[0], fail[0], response8, fail_cnt8}, 32'd0);
        chk("async reset d1", {scan_en[1], scan_si[1], busy[1], done[1], fail[1], response4, fail_cnt4}, 32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);

        // 256 back-to-back failing tests with start held high.
        inv[0] = 1'b0; pattern[0] = 8'hA5; expected[0] = 8'h5A; mask[0] = 8'hFF; start[0] = 1'b1;
        for (int r = 0; r < 256; r++) begin
            w = 0;
            while (!done[0] && w < 40) begin @(negedge clk); w++; end
            if (!done[0]) chk("sat done timeout", {31'b0, done[0]}, 32'd1);
            if (r == 255) start[0] = 1'b0;
            @(negedge clk);
            chk("gap idle", {busy[0], done[0]}, 32'd0);
            if (r < 255) begin
                @(negedge clk);
                chk("gap load", busy[0], 1);
            end
        end
        chk("saturated fail_cnt", fail_cnt8, 8'd255);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
